// File: rtl/wb_pkg.sv
// Shared types and encodings for the write-back stage.
// Struct fields are sized for the widest supported build (XLEN=64); narrower builds use the low bits.
package wb_pkg;

    localparam int WB_XLEN_MAX = 64;
    localparam int WB_RA_W_MAX = 8;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [1:0]             resultsrc;
        logic [2:0]             funct3;
        logic [WB_RA_W_MAX-1:0] rd;
        logic                   regwrite;
        logic [WB_XLEN_MAX-1:0] aluresult;
        logic [WB_XLEN_MAX-1:0] pcplus4;
    } wb_in_t;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_e;

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational sub-word load alignment: shifts the memory word down by the byte offset,
// then sign/zero-extends per funct3 and flags offsets that break natural alignment.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data,
    output logic             misaligned
);

    logic [63:0] wide;
    logic [63:0] shifted;
    logic [63:0] ext;
    logic [2:0]  off3;
    logic        unused_ext;

    // Work at 64 bits throughout so one body serves both XLEN builds.
    always_comb begin
        wide               = '0;
        wide[XLEN-1:0]     = rdata;
        off3               = '0;
        off3[OFF_W-1:0]    = offset;
        shifted            = wide >> {off3, 3'b000};
        ext                = '0;
        misaligned         = 1'b0;
        case (funct3)
            F3_LB:  ext = {{56{shifted[7]}}, shifted[7:0]};
            F3_LH: begin
                ext        = {{48{shifted[15]}}, shifted[15:0]};
                misaligned = off3[0];
            end
            F3_LW: begin
                ext        = {{32{shifted[31]}}, shifted[31:0]};
                misaligned = |off3[1:0];
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    ext        = shifted;
                    misaligned = |off3;
                end
            end
            F3_LBU: ext = {56'b0, shifted[7:0]};
            F3_LHU: begin
                ext        = {48'b0, shifted[15:0]};
                misaligned = off3[0];
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    ext        = {32'b0, shifted[31:0]};
                    misaligned = |off3[1:0];
                end
            end
            default: ext = '0;
        endcase
        data = ext[XLEN-1:0];
    end

    assign unused_ext = ^ext;

endmodule

// File: rtl/wb_unit.sv
// Registered write-back stage: retires ALU/PC+4 results directly, waits for late load data otherwise.
// Optional macro WB_MISALIGN_TRAP_EN turns misaligned loads into a misalign pulse carrying the faulting address.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  wb_in_t          in,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            flush,
    output logic            regwrite,
    output logic [RA_W-1:0] rd,
    output logic [XLEN-1:0] result,
    output logic            misalign
);

    localparam int OFF_W = $clog2(XLEN/8);

    wb_state_e       state;
    logic [2:0]      lat_funct3;
    logic [RA_W-1:0] lat_rd;
    logic            lat_regwrite;
    logic [XLEN-1:0] lat_addr;
    logic            accept;
    logic            accept_load;
    logic [XLEN-1:0] ld_data;
    logic            ld_misaligned;
    logic [RA_W-1:0] in_rd;
    logic            unused_in;

    assign in_ready    = (state == IDLE);
    assign accept      = in_ready && in_valid && !flush;
    assign accept_load = accept && (in.resultsrc == RES_MEM);
    assign in_rd       = in.rd[RA_W-1:0];
    assign unused_in   = ^{in.rd, in.aluresult, in.pcplus4};

    load_align #(
        .XLEN (XLEN),
        .OFF_W(OFF_W)
    ) u_align (
        .rdata     (mem_rdata),
        .offset    (lat_addr[OFF_W-1:0]),
        .funct3    (lat_funct3),
        .data      (ld_data),
        .misaligned(ld_misaligned)
    );

    // Load context is pure data; only meaningful while in WAIT_MEM.
    always_ff @(posedge clk) begin
        if (accept_load) begin
            lat_funct3   <= in.funct3;
            lat_rd       <= in_rd;
            lat_regwrite <= in.regwrite;
            lat_addr     <= in.aluresult[XLEN-1:0];
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign = misalign_q;
`else
    logic unused_misaligned;
    assign misalign          = 1'b0;
    assign unused_misaligned = ld_misaligned;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            regwrite <= 1'b0;
            rd       <= '0;
            result   <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            regwrite <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in.resultsrc == RES_MEM) begin
                            state <= WAIT_MEM;
                        end else begin
                            rd       <= in_rd;
                            regwrite <= in.regwrite && (in_rd != '0);
                            case (in.resultsrc)
                                RES_ALU: result <= in.aluresult[XLEN-1:0];
                                RES_PC4: result <= in.pcplus4[XLEN-1:0];
                                default: result <= '0;
                            endcase
                        end
                    end
                end
                WAIT_MEM: begin
                    // Flush wins over a same-cycle data return.
                    if (flush) begin
                        state <= IDLE;
                    end else if (mem_rvalid) begin
                        state <= IDLE;
                        rd    <= lat_rd;
`ifdef WB_MISALIGN_TRAP_EN
                        if (ld_misaligned) begin
                            misalign_q <= 1'b1;
                            result     <= lat_addr;
                        end else begin
                            regwrite <= lat_regwrite && (lat_rd != '0);
                            result   <= ld_data;
                        end
`else
                        regwrite <= lat_regwrite && (lat_rd != '0);
                        result   <= ld_data;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: a 32-bit instance for most scenarios and a 64-bit one for LWU.
module tb_wb_unit;
    import wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid, flush, mem_rvalid;
    logic [31:0] mem_rdata;
    wb_in_t      in_s;
    logic        in_ready, regwrite, misalign;
    logic [4:0]  rd;
    logic [31:0] result;

    logic        v64, f64, rv64;
    logic [63:0] rdata64;
    wb_in_t      in64;
    logic        rdy64, rw64, mis64;
    logic [4:0]  rd64;
    logic [63:0] res64;

    int n_checks;
    int n_fail;

    wb_unit #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_s),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .regwrite(regwrite), .rd(rd), .result(result), .misalign(misalign)
    );

    wb_unit #(.XLEN(64), .RA_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in(in64),
        .mem_rvalid(rv64), .mem_rdata(rdata64), .flush(f64),
        .regwrite(rw64), .rd(rd64), .result(res64), .misalign(mis64)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] src, input logic [2:0] f3, input logic [7:0] dst,
                          input logic rw, input logic [63:0] alu, input logic [63:0] pc4);
        in_s.resultsrc = src;
        in_s.funct3    = f3;
        in_s.rd        = dst;
        in_s.regwrite  = rw;
        in_s.aluresult = alu;
        in_s.pcplus4   = pc4;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", regwrite); end
        n_checks++; if (rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        set_in(RES_ALU, 3'b000, 8'd5, 1'b1, 64'h1234, 64'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %b want 1", regwrite); end
        n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", rd); end
        n_checks++; if (result !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_result: got %h want 00001234", result); end
        step();
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL alu_pulse: got %b want 0", regwrite); end
        n_checks++; if (result !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_hold: got %h want 00001234", result); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        set_in(RES_ALU, 3'b000, 8'd3, 1'b1, 64'hAAAA, 64'h0);
        step();
        n_checks++; if (result !== 32'h0000_AAAA || rd !== 5'd3 || regwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_alu: got %h/%0d/%b want 0000aaaa/3/1", result, rd, regwrite); end
        set_in(RES_PC4, 3'b000, 8'd4, 1'b1, 64'hDEAD, 64'h104);
        step();
        n_checks++; if (result !== 32'h0000_0104 || rd !== 5'd4 || regwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_pc4: got %h/%0d/%b want 00000104/4/1", result, rd, regwrite); end
        set_in(2'b11, 3'b000, 8'd6, 1'b1, 64'h99, 64'h200);
        step();
        n_checks++; if (result !== 32'h0 || rd !== 5'd6 || regwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_zero: got %h/%0d/%b want 00000000/6/1", result, rd, regwrite); end
        in_valid = 1'b0;
        step();
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", regwrite); end
    endtask

    task automatic test_lb();
        // Stray data return while idle must not write.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b want 0", regwrite); end
        set_in(RES_MEM, F3_LB, 8'd7, 1'b1, 64'h1003, 64'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_ready_wait1: got %b want 0", in_ready); end
        step();
        n_checks++; if (in_ready !== 1'b0 || regwrite !== 1'b0) begin n_fail++; $display("FAIL lb_ready_wait2: got %b/%b want 0/0", in_ready, regwrite); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_0000;
        step();
        mem_rvalid = 1'b0;
        n_checks++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL lb_regwrite: got %b want 1", regwrite); end
        n_checks++; if (result !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_result: got %h want ffffff80", result); end
        n_checks++; if (rd !== 5'd7 || in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_rd_ready: got %0d/%b want 7/1", rd, in_ready); end
        step();
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL lb_pulse: got %b want 0", regwrite); end
    endtask

    task automatic test_lhu();
        set_in(RES_MEM, F3_LHU, 8'd11, 1'b1, 64'h2002, 64'h0);
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBEEF_1234;
        step();
        mem_rvalid = 1'b0;
        n_checks++; if (result !== 32'h0000_BEEF || regwrite !== 1'b1) begin n_fail++; $display("FAIL lhu_result: got %h/%b want 0000beef/1", result, regwrite); end
    endtask

    task automatic test_lwu64();
        in64.resultsrc = RES_MEM;
        in64.funct3    = F3_LWU;
        in64.rd        = 8'd13;
        in64.regwrite  = 1'b1;
        in64.aluresult = 64'h1004;
        in64.pcplus4   = 64'h0;
        v64 = 1'b1;
        step();
        v64 = 1'b0;
        n_checks++; if (rdy64 !== 1'b0) begin n_fail++; $display("FAIL lwu64_ready: got %b want 0", rdy64); end
        rv64    = 1'b1;
        rdata64 = 64'h8000_0001_DEAD_BEEF;
        step();
        rv64 = 1'b0;
        n_checks++; if (res64 !== 64'h0000_0000_8000_0001) begin n_fail++; $display("FAIL lwu64_result: got %h want 0000000080000001", res64); end
        n_checks++; if (rw64 !== 1'b1 || rd64 !== 5'd13) begin n_fail++; $display("FAIL lwu64_write: got %b/%0d want 1/13", rw64, rd64); end
    endtask

    task automatic test_misalign();
        set_in(RES_MEM, F3_LW, 8'd9, 1'b1, 64'h3002, 64'h0);
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_1234;
        step();
        mem_rvalid = 1'b0;
        n_checks++; if (rd !== 5'd9) begin n_fail++; $display("FAIL mis_rd: got %0d want 9", rd); end
`ifdef WB_MISALIGN_TRAP_EN
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL mis_regwrite: got %b want 0", regwrite); end
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", misalign); end
        n_checks++; if (result !== 32'h0000_3002) begin n_fail++; $display("FAIL mis_result: got %h want 00003002", result); end
`else
        n_checks++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL mis_regwrite: got %b want 1", regwrite); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b want 0", misalign); end
        n_checks++; if (result !== 32'h0000_CAFE) begin n_fail++; $display("FAIL mis_result: got %h want 0000cafe", result); end
`endif
        step();
        n_checks++; if (misalign !== 1'b0 || regwrite !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b/%b want 0/0", misalign, regwrite); end
    endtask

    task automatic test_flush();
        set_in(RES_MEM, F3_LW, 8'd8, 1'b1, 64'h4000, 64'h0);
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        step();
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        n_checks++; if (regwrite !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_load: got %b/%b want 0/1", regwrite, in_ready); end
        // Flush in IDLE holds off an offered instruction for that cycle only.
        set_in(RES_ALU, 3'b000, 8'd10, 1'b1, 64'h55, 64'h0);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (regwrite !== 1'b0 || rd === 5'd10) begin n_fail++; $display("FAIL flush_idle: got %b/%0d want 0/not 10", regwrite, rd); end
        step();
        n_checks++; if (regwrite !== 1'b1 || result !== 32'h0000_0055) begin n_fail++; $display("FAIL flush_release: got %b/%h want 1/00000055", regwrite, result); end
        set_in(RES_ALU, 3'b000, 8'd0, 1'b1, 64'h77, 64'h0);
        step();
        in_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b0 || result !== 32'h0000_0077 || rd !== 5'd0) begin n_fail++; $display("FAIL rd0: got %b/%h/%0d want 0/00000077/0", regwrite, result, rd); end
    endtask

    task automatic test_reset_mid_load();
        set_in(RES_MEM, F3_LB, 8'd12, 1'b1, 64'h5000, 64'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait: got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (result !== 32'h0 || rd !== 5'd0 || regwrite !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_async: got %h/%0d/%b/%b want 0/0/0/1", result, rd, regwrite, in_ready); end
        step();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00FF;
        step();
        mem_rvalid = 1'b0;
        n_checks++; if (regwrite !== 1'b0 || result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_nowrite: got %b/%h want 0/0", regwrite, result); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        in_s       = '0;
        v64        = 1'b0;
        f64        = 1'b0;
        rv64       = 1'b0;
        rdata64    = '0;
        in64       = '0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_lb();
        test_lhu();
        test_lwu64();
        test_misalign();
        test_flush();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
